// File: rtl/updown_step_driver_if.sv
// updown_step_driver_if
//   Bundles the signals between a target-issuing controller, the step driver
//   and the datapath up/down counter it commands.
//   Parameter:
//     WIDTH        counter / target width in bits
//   Signals:
//     req_valid    controller has a target request
//     req_target   requested final count, taken on the accepting edge
//     req_ready    driver is idle and will accept a request
//     abort        controller cancels the active request
//     up_enable    one-cycle increment command to the counter
//     down_enable  one-cycle decrement command to the counter
//     busy         driver is stepping (including inter-pulse gaps)
//     done         one-cycle completion pulse
//     shadow_count driver's copy of the counter value
//   Modports:
//     master       controller side
//     slave        step driver side
interface updown_step_driver_if #(
  parameter int WIDTH = 4
);

  logic             req_valid;
  logic [WIDTH-1:0] req_target;
  logic             req_ready;
  logic             abort;
  logic             up_enable;
  logic             down_enable;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shadow_count;

  modport master (
    output req_valid, req_target, abort,
    input  req_ready, up_enable, down_enable, busy, done, shadow_count
  );

  modport slave (
    input  req_valid, req_target, abort,
    output req_ready, up_enable, down_enable, busy, done, shadow_count
  );

endinterface

// File: rtl/updown_step_driver.sv
// updown_step_driver
//   Steps an external up/down counter toward a requested target by issuing
//   single-cycle up/down pulses, keeping a shadow copy of the counter value.
//   The counter is never driven past the target and never wraps; if the
//   target is not reachable exactly, stepping stops at the nearest value
//   short of it.
//   Parameters:
//     WIDTH      counter / target width
//     UP_STEP    counter increment per up pulse
//     DOWN_STEP  counter decrement per down pulse
//     GAP        idle cycles between consecutive pulses
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        updown_step_driver_if slave modport (handshake, pulses,
//                status, shadow count)
module updown_step_driver #(
  parameter int WIDTH     = 4,
  parameter int UP_STEP   = 1,
  parameter int DOWN_STEP = 1,
  parameter int GAP       = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  updown_step_driver_if.slave bus
);

  // Gap counter only needs to hold GAP-1.
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  localparam logic [WIDTH:0]   UP_X   = (WIDTH + 1)'(UP_STEP);
  localparam logic [WIDTH:0]   DOWN_X = (WIDTH + 1)'(DOWN_STEP);
  localparam logic [WIDTH-1:0] UP_W   = WIDTH'(UP_STEP);
  localparam logic [WIDTH-1:0] DOWN_W = WIDTH'(DOWN_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             up_pulse, down_pulse;
  logic             can_up, can_down;
  logic [WIDTH-1:0] shadow_up, shadow_down;

  // One extra bit keeps shadow+step and target+step from wrapping.
  function automatic logic step_possible(input logic [WIDTH-1:0] s,
                                         input logic [WIDTH-1:0] t);
    logic [WIDTH:0] sx;
    logic [WIDTH:0] tx;
    sx = {1'b0, s};
    tx = {1'b0, t};
    return ((sx + UP_X) <= tx) || (sx >= (tx + DOWN_X));
  endfunction

  assign can_up      = (({1'b0, shadow_q} + UP_X) <= {1'b0, target_q});
  assign can_down    = ({1'b0, shadow_q} >= ({1'b0, target_q} + DOWN_X));
  assign shadow_up   = shadow_q + UP_W;
  assign shadow_down = shadow_q - DOWN_W;

  // State, shadow, latched target and gap counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      target_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      target_q <= target_d;
      gap_q    <= gap_d;
    end
  end

  // Next-state and pulse decode. After each pulse the post-pulse shadow is
  // checked for another legal step, so the final pulse goes straight to
  // DONE without an extra decision cycle or a trailing gap. Abort masks the
  // pulse of the cycle it is sampled in so the shadow never advances past
  // what the counter actually received.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    target_d   = target_q;
    gap_d      = gap_q;
    up_pulse   = 1'b0;
    down_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          target_d = bus.req_target;
          state_d  = S_STEP;
        end
      end
      S_STEP: begin
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (can_up || can_down) begin
          up_pulse   = can_up;
          down_pulse = !can_up;
          shadow_d   = can_up ? shadow_up : shadow_down;
          if (!step_possible(shadow_d, target_q)) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_STEP;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (gap_q == '0) begin
          state_d = S_STEP;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q == S_STEP) || (state_q == S_GAP);
  assign bus.done         = (state_q == S_DONE);
  assign bus.up_enable    = up_pulse;
  assign bus.down_enable  = down_pulse;
  assign bus.shadow_count = shadow_q;

endmodule

// File: tb/tb_updown_step_driver.sv
// tb_updown_step_driver
//   Scoreboard bench for updown_step_driver (UP_STEP=3, DOWN_STEP=2, GAP=2).
//   The stimulus side derives each request's expected pulses and done from
//   plain arithmetic on the requested distance and queues them; a monitor
//   on the falling edge pops and compares whenever the DUT pulses or
//   signals done, and checks ready/busy every cycle.
module tb_updown_step_driver;

  localparam int WIDTH = 4;
  localparam int UP    = 3;
  localparam int DOWN  = 2;
  localparam int G     = 2;

  typedef struct {
    bit is_done;
    bit is_up;
    int cyc;
    int shadow;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_s = 0;
  bit   outstanding = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Edge counter: an event in cycle k of a request accepted on edge A is
  // observed at the falling edge while cyc == A + k - 1.
  always @(posedge clk) cyc <= cyc + 1;

  updown_step_driver_if #(.WIDTH(WIDTH)) bus ();

  updown_step_driver #(
    .WIDTH    (WIDTH),
    .UP_STEP  (UP),
    .DOWN_STEP(DOWN),
    .GAP      (G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic flag_fail(input string name, input int actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d with no matching expectation (t=%0t)", name, actual, $time);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ready"},  bus.req_ready,    1);
    check_output({tag, "_busy"},   bus.busy,         0);
    check_output({tag, "_done"},   bus.done,         0);
    check_output({tag, "_up"},     bus.up_enable,    0);
    check_output({tag, "_down"},   bus.down_enable,  0);
    check_output({tag, "_shadow"}, bus.shadow_count, 0);
  endtask

  // Issue one request. abort_k > 0 raises abort in that cycle of the
  // request (folded into the active window); reset_k > 0 instead pulls
  // rst_n low partway through cycle reset_k.
  task automatic apply_stimulus(input int target, input int abort_k, input int reset_k);
    int  s, n, d, pc, acc, t, dc;
    bit  up;
    exp_t e;
    @(posedge clk); #1;
    t = 0;
    while (!bus.req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_output("ready_before_request", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_target = WIDTH'(target);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    acc = cyc;

    s = model_s;
    if (target > s) begin
      up = 1'b1;
      n  = (target - s) / UP;
    end else if (target < s) begin
      up = 1'b0;
      n  = (s - target) / DOWN;
    end else begin
      up = 1'b0;
      n  = 0;
    end
    d = (n == 0) ? 2 : (n - 1) * (G + 1) + 2;
    if (abort_k > 0) abort_k = ((abort_k - 1) % (d - 1)) + 1;
    for (int i = 0; i < n; i++) begin
      pc = 1 + i * (G + 1);
      if (abort_k > 0 && pc >= abort_k) break;
      e.is_done = 1'b0;
      e.is_up   = up;
      e.cyc     = acc + pc - 1;
      e.shadow  = s;
      exp_q.push_back(e);
      s = up ? s + UP : s - DOWN;
    end
    dc = (abort_k > 0) ? abort_k + 1 : d;
    e.is_done = 1'b1;
    e.is_up   = 1'b0;
    e.cyc     = acc + dc - 1;
    e.shadow  = s;
    exp_q.push_back(e);
    model_s     = s;
    outstanding = 1'b1;

    if (reset_k > 0) begin
      repeat (reset_k - 1) begin
        @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1 check_reset_values("mid_reset");
      exp_q.delete();
      outstanding = 1'b0;
      model_s     = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end

    if (abort_k > 0) begin
      repeat (abort_k - 1) begin
        @(posedge clk); #1;
      end
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
    end

    t = 0;
    while (outstanding && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (outstanding) begin
      flag_fail("request_timeout", target);
      exp_q.delete();
      outstanding = 1'b0;
    end
  endtask

  // Monitor: pops expected pulses/done as the DUT presents them and checks
  // handshake status every cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   done_cycle;
    if (rst_n) begin
      done_cycle = outstanding && exp_q.size() > 0 && exp_q[$].is_done
                   && exp_q[$].cyc == cyc;
      check_output("pulse_exclusive", (bus.up_enable && bus.down_enable) ? 1 : 0, 0);
      check_output("ready", bus.req_ready, outstanding ? 0 : 1);
      check_output("busy", bus.busy, (outstanding && !done_cycle) ? 1 : 0);
      check_output("done", bus.done, done_cycle ? 1 : 0);
      if (bus.up_enable || bus.down_enable) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          flag_fail("unexpected_pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          check_output("pulse_dir_up", bus.up_enable, e.is_up);
          check_output("pulse_cycle", cyc, e.cyc);
          check_output("pulse_shadow", bus.shadow_count, e.shadow);
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_done", cyc);
        end else if (!exp_q[0].is_done) begin
          flag_fail("done_before_pulses", cyc);
          while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_done) break;
          end
        end else begin
          e = exp_q.pop_front();
          check_output("done_cycle", cyc, e.cyc);
          check_output("done_shadow", bus.shadow_count, e.shadow);
        end
      end
      if (done_cycle) outstanding = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tgt, ab;
    bus.req_valid  = 1'b0;
    bus.req_target = '0;
    bus.abort      = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    apply_stimulus(10, 0, 0);   // 0 -> 9, three up pulses, no overshoot
    apply_stimulus(0, 0, 0);    // 9 -> 1, four down pulses
    apply_stimulus(15, 0, 2);   // reset mid-request
    apply_stimulus(15, 0, 0);   // fresh start: 0 -> 15, no wrap
    apply_stimulus(15, 0, 0);   // target equals count: zero pulses
    apply_stimulus(14, 0, 0);   // distance below DOWN step: zero pulses
    apply_stimulus(10, 3, 0);   // abort during the gap after the first pulse
    apply_stimulus(0, 1, 0);    // abort in the very first cycle

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
      end
      tgt = $urandom_range(0, 15);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      apply_stimulus(tgt, ab, 0);
    end

    repeat (3) @(posedge clk);
    #1 check_output("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
